// File: rtl/dmem_lsu.sv
// Byte-addressable data memory for the MEM stage. It takes valid/ready requests,
// supports byte/half/word loads and stores, holds one registered response, and
// counts error responses with saturation.
`timescale 1ns/1ps
module dmem_lsu #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned AW          = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_word,
    output logic [15:0]   err_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned NB    = 4;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [7:0]       mem [DEPTH_BYTES];
    logic             accept_c;
    logic [1:0]       err_c;
    logic [NB-1:0]    be_c;
    logic [IDX_W-1:0] bidx_c [NB];
    logic [31:0]      raw_c;
    logic [31:0]      load_c;
    logic [IDX_W-1:0] dbg_idx_c;
    logic             unused_dbg_lsb;

    assign req_ready      = !rsp_valid || rsp_ready;
    assign accept_c       = req_valid && req_ready;
    assign unused_dbg_lsb = ^dbg_addr[1:0];

    // Error classification in priority order: size, alignment, range.
    always_comb begin
        err_c = ERR_OK;
        if (req_size == ERR_SIZE) begin
            err_c = ERR_SIZE;
        end else if ((req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
            err_c = ERR_ALIGN;
        end else if (|req_addr[AW-1:IDX_W]) begin
            err_c = ERR_RANGE;
        end
    end

    // Byte lane enables and the four consecutive byte indices from req_addr.
    always_comb begin
        be_c = 4'b0000;
        case (req_size)
            SZ_BYTE: be_c = 4'b0001;
            SZ_HALF: be_c = 4'b0011;
            SZ_WORD: be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
        for (int k = 0; k < NB; k++) begin
            bidx_c[k] = req_addr[IDX_W-1:0] + IDX_W'(k);
        end
    end

    // Gather the raw little-endian bytes and apply sign or zero extension.
    always_comb begin
        raw_c  = {mem[bidx_c[3]], mem[bidx_c[2]], mem[bidx_c[1]], mem[bidx_c[0]]};
        load_c = 32'd0;
        case (req_size)
            SZ_BYTE: load_c = req_unsigned ? {24'd0, raw_c[7:0]}
                                           : {{24{raw_c[7]}}, raw_c[7:0]};
            SZ_HALF: load_c = req_unsigned ? {16'd0, raw_c[15:0]}
                                           : {{16{raw_c[15]}}, raw_c[15:0]};
            SZ_WORD: load_c = raw_c;
            default: load_c = 32'd0;
        endcase
    end

    // Storage array: cleared on reset, written by error-free accepted stores.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (accept_c && req_we && err_c == ERR_OK) begin
            for (int k = 0; k < NB; k++) begin
                if (be_c[k]) begin
                    mem[bidx_c[k]] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Single-entry response register: load on accept, clear when consumed.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= ERR_OK;
        end else if (accept_c) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (req_we || err_c != ERR_OK) ? 32'd0 : load_c;
            rsp_err   <= err_c;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Saturating count of accepted requests that returned an error.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_count <= 16'd0;
        end else if (accept_c && err_c != ERR_OK && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end

    // Combinational debug view of the aligned word containing dbg_addr.
    always_comb begin
        dbg_idx_c = {dbg_addr[IDX_W-1:2], 2'b00};
        dbg_word  = 32'd0;
        if (!(|dbg_addr[AW-1:IDX_W])) begin
            dbg_word = {mem[dbg_idx_c + IDX_W'(3)], mem[dbg_idx_c + IDX_W'(2)],
                        mem[dbg_idx_c + IDX_W'(1)], mem[dbg_idx_c]};
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed plan cases plus randomized
// back-to-back traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_lsu;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_word;
    logic [15:0] err_count;

    int n_checks;
    int n_pass;

    logic [7:0]  mm [DEPTH];
    int unsigned m_count;

    dmem_lsu #(.DEPTH_BYTES(DEPTH), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_addr(dbg_addr),
        .dbg_word(dbg_word), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'd0;
        m_count = 0;
    endtask

    // Reference behaviour of one accepted request, from the memory rules.
    task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic [1:0] er);
        int n;
        longint v;
        rd = 32'd0;
        if (sz == 2'd3) er = 2'd3;
        else if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) er = 2'd1;
        else if (a >= DEPTH) er = 2'd2;
        else er = 2'd0;
        if (er != 2'd0) begin
            if (m_count < 65535) m_count++;
            return;
        end
        n = 1 << sz;
        if (we) begin
            for (int i = 0; i < n; i++) mm[a + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(mm[a + i]) << (8 * i);
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v -= (longint'(1) << (8 * n));
            rd = 32'(v);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        if (a >= DEPTH) return 32'd0;
        b = int'(a) & ~3;
        return {mm[b + 3], mm[b + 2], mm[b + 1], mm[b]};
    endfunction

    // Issue one request, wait for acceptance, sample the response 1 ns after the edge.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic v, output logic [31:0] rd, output logic [1:0] er,
                          output logic [31:0] ex_rd, output logic [1:0] ex_er);
        int w;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            n_checks++;
            $display("FAIL req_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        model_access(we, sz, uns, a, wd, ex_rd, ex_er);
        #1;
        v = rsp_valid; rd = rsp_rdata; er = rsp_err;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready);
        else n_pass++;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 2'd0)
            $display("FAIL reset_rsp: got v=%0b d=%h e=%0d want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        else n_pass++;
        n_checks++;
        if (err_count !== 16'd0 || dbg_word !== 32'd0)
            $display("FAIL reset_cnt_dbg: got cnt=%0d dbg=%h want 0/0", err_count, dbg_word);
        else n_pass++;
    endtask

    task automatic test_store_load();
        logic v; logic [31:0] rd, erd; logic [1:0] er, eer;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_80F1, v, rd, er, erd, eer);
        n_checks++;
        if (v !== 1'b1 || rd !== 32'd0 || er !== 2'd0)
            $display("FAIL sw_rsp: got v=%0b d=%h e=%0d want 1/0/0", v, rd, er);
        else n_pass++;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, v, rd, er, erd, eer);
        n_checks++;
        if (v !== 1'b1 || rd !== 32'h8000_80F1 || er !== 2'd0)
            $display("FAIL lw_rsp: got v=%0b d=%h e=%0d want 1/800080f1/0", v, rd, er);
        else n_pass++;
        dbg_addr = 32'h12;
        #1;
        n_checks++;
        if (dbg_word !== 32'h8000_80F1) $display("FAIL dbg_word: got %h want 800080f1", dbg_word);
        else n_pass++;
    endtask

    task automatic test_extension();
        logic v; logic [31:0] rd, erd; logic [1:0] er, eer;
        logic [31:0] exp_tab [4];
        logic [1:0]  sz_tab [4];
        logic        un_tab [4];
        logic [31:0] ad_tab [4];
        exp_tab = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8000, 32'h0000_8000};
        sz_tab  = '{2'd0, 2'd0, 2'd1, 2'd1};
        un_tab  = '{1'b0, 1'b1, 1'b0, 1'b1};
        ad_tab  = '{32'h10, 32'h10, 32'h12, 32'h12};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz_tab[i], un_tab[i], ad_tab[i], 32'd0, v, rd, er, erd, eer);
            n_checks++;
            if (rd !== exp_tab[i] || er !== 2'd0)
                $display("FAIL ext_%0d: got d=%h e=%0d want %h/0", i, rd, er, exp_tab[i]);
            else n_pass++;
        end
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h1234_56AA, v, rd, er, erd, eer);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, v, rd, er, erd, eer);
        n_checks++;
        if (rd !== 32'hAA00_80F1) $display("FAIL sb_merge: got %h want aa0080f1", rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic v; logic [31:0] rd, erd; logic [1:0] er, eer;
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, v, rd, er, erd, eer);
        n_checks++;
        if (er !== 2'd1 || rd !== 32'd0) $display("FAIL err_lw_mis: got e=%0d d=%h want 1/0", er, rd);
        else n_pass++;
        do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'hBEEF, v, rd, er, erd, eer);
        dbg_addr = 32'h0;
        #1;
        n_checks++;
        if (er !== 2'd1 || dbg_word !== 32'd0)
            $display("FAIL err_sh_mis: got e=%0d mem=%h want 1/0", er, dbg_word);
        else n_pass++;
        do_req(1'b0, 2'd2, 1'b0, DEPTH, 32'd0, v, rd, er, erd, eer);
        n_checks++;
        if (er !== 2'd2 || rd !== 32'd0) $display("FAIL err_range: got e=%0d d=%h want 2/0", er, rd);
        else n_pass++;
        do_req(1'b0, 2'd3, 1'b0, 32'h11, 32'd0, v, rd, er, erd, eer);
        n_checks++;
        if (er !== 2'd3) $display("FAIL err_size: got e=%0d want 3", er);
        else n_pass++;
        n_checks++;
        if (err_count !== 16'd4) $display("FAIL err_count: got %0d want 4", err_count);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic v; logic [31:0] rd, erd, erd2; logic [1:0] er, eer, eer2;
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, v, rd, er, erd, eer);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14;
        req_wdata = 32'd0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hAA00_80F1 || rsp_err !== 2'd0)
                $display("FAIL bp_hold_%0d: got rdy=%0b v=%0b d=%h e=%0d want 0/1/aa0080f1/0",
                         i, req_ready, rsp_valid, rsp_rdata, rsp_err);
            else n_pass++;
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk);
        model_access(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, erd2, eer2);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== erd2 || rsp_err !== eer2)
            $display("FAIL bp_release: got v=%0b d=%h e=%0d want 1/%h/%0d", rsp_valid, rsp_rdata, rsp_err, erd2, eer2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] erd, a, wd; logic [1:0] eer, sz; logic we, un;
        int bad;
        bad = 0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 63));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = a + DEPTH;
            wd = $urandom;
            req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
            req_valid = 1'b1;
            @(posedge clk);
            model_access(we, sz, un, a, wd, erd, eer);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== erd || rsp_err !== eer) begin
                if (bad < 10)
                    $display("FAIL b2b_%0d: we=%0b sz=%0d a=%h got v=%0b d=%h e=%0d want 1/%h/%0d",
                             k, we, sz, a, rsp_valid, rsp_rdata, rsp_err, erd, eer);
                bad++;
            end else n_pass++;
        end
        @(negedge clk); req_valid = 1'b0;
        n_checks++;
        if (err_count !== 16'(m_count)) $display("FAIL b2b_err_count: got %0d want %0d", err_count, m_count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 32'($urandom_range(0, 70));
            #1;
            n_checks++;
            if (dbg_word !== model_word(dbg_addr))
                $display("FAIL dbg_sweep_%0d: addr=%h got %h want %h", i, dbg_addr, dbg_word, model_word(dbg_addr));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic v; logic [31:0] rd, erd; logic [1:0] er, eer;
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h5A5A_1234, v, rd, er, erd, eer);
        #2;
        rst_n = 1'b1;
        #1;
        dbg_addr = 32'h10;
        #0.5;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 2'd0 || req_ready !== 1'b1)
            $display("FAIL rst_mid_rsp: got v=%0b d=%h e=%0d rdy=%0b want 0/0/0/1", rsp_valid, rsp_rdata, rsp_err, req_ready);
        else n_pass++;
        n_checks++;
        if (err_count !== 16'd0 || dbg_word !== 32'd0)
            $display("FAIL rst_mid_state: got cnt=%0d dbg=%h want 0/0", err_count, dbg_word);
        else n_pass++;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, v, rd, er, erd, eer);
        n_checks++;
        if (v !== 1'b1 || rd !== 32'd0 || er !== 2'd0)
            $display("FAIL rst_mid_lw: got v=%0b d=%h e=%0d want 1/0/0", v, rd, er);
        else n_pass++;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1; dbg_addr = 32'd0;
        n_checks = 0; n_pass = 0;
        model_clear();
        #1 rst_n = 1'b1;
        #2;
        test_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        test_store_load();
        test_extension();
        test_errors();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised byte-addressable data memory with a valid/ready request port, registered responses and full RISC-V load/store width support (byte, half and word, with sign or zero extension). It sits in the MEM stage of the risc_v_pipeline as the successor to the fixed 32-byte word-only data memory. It adds alignment, range and size checking with error reporting, a response hold register for back-pressure, and a saturating error counter. A combinational debug word port is kept for the testbench and the register/memory viewer.

## Interface
Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; must be a power of two and at least 4.
- AW, 32: width of the request and debug addresses.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted; equals !rsp_valid || rsp_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data; the low 1, 2 or 4 bytes are used.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- dbg_addr  in  AW  debug byte address; bits [1:0] are ignored.
- dbg_word  out  32  little-endian word at {dbg_addr[AW-1:2],2'b00}; 0 if out of range.
- err_count  out  16  count of error responses; saturates at 16'hFFFF.

## Operation
- Storage is DEPTH_BYTES bytes, little-endian; the byte at addr holds bits [7:0].
- A request is accepted on a rising edge when req_valid && req_ready.
- Error checks, evaluated in priority order:
  - size==11 gives err 11.
  - Otherwise, half with addr[0]!=0, or word with addr[1:0]!=0, gives err 01.
  - Otherwise, addr >= DEPTH_BYTES gives err 10. Alignment guarantees the last byte is in range.
- Accepted store with no error:
  - writes bytes addr..addr+n-1 from req_wdata[8n-1:0] on the accept edge;
  - all other bytes are unchanged;
  - the response is rsp_rdata=0, rsp_err=00.
- Accepted store with an error: no memory write.
- Accepted load with no error:
  - reads bytes addr..addr+n-1 as they were before the accept edge;
  - sign-extends from the top read bit when req_unsigned=0, zero-extends otherwise;
  - word loads ignore req_unsigned.
- Accepted load with an error: rsp_rdata=0.
- Error counting: on each accepted request with err!=00, err_count increments unless it is already FFFF.
- Response register behaviour:
  - It is a single entry.
  - It is loaded on accept.
  - It clears (rsp_valid=0) on an rsp_ready edge with no new accept.
  - When a consumed response and a new accept occur on the same edge, the new response replaces the old one.
- dbg_word reads the array combinationally; a store is visible from the cycle after its accept edge.
- Reset, asserted at any time including while a response is pending:
  - zeroes every memory byte;
  - sets rsp_valid=0, rsp_rdata=0, rsp_err=00 and err_count=0;
  - discards any in-flight response.
- Reset values of outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, dbg_word=0, err_count=0.

## Timing
- Load latency is 1: a request accepted at edge N gives rsp_valid=1 with data from edge N.
- Throughput is one request per cycle while rsp_ready=1.
- Store followed by load:
  - a store accepted at N and a load of the same address accepted at N+1 return the stored data;
  - a load cannot be accepted at the same edge as the store.
- Back-pressure: with rsp_valid=1 and rsp_ready=0, req_ready=0 and the response outputs stay stable.
- Input stability: req_* must be stable while req_valid=1 and req_ready=0.
- Reset is asynchronous: outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then SW 0x8000_80F1 @0x10, then LW @0x10:
  - rsp 0x800080F1, err 00;
  - dbg_addr=0x12 gives dbg_word 0x800080F1.
- Sign and zero extension on the same word:
  - LB @0x10 gives 0xFFFFFFF1;
  - LBU @0x10 gives 0x000000F1;
  - LH @0x12 gives 0xFFFF8000;
  - LHU @0x12 gives 0x00008000.
- SB 0xAA @0x13, then LW @0x10: 0xAA0080F1, confirming the other bytes are untouched.
- Errors:
  - LW @0x11 gives err 01, rdata 0;
  - SH @0x3 gives err 01 and memory is unchanged;
  - LW @DEPTH_BYTES gives err 10;
  - size=11 @0x11 gives err 11, showing size has priority;
  - err_count ends at 4.
- Back-pressure:
  - hold rsp_ready=0 for 3 cycles after an LW: req_ready stays 0 and rsp stays stable;
  - drop to rsp_ready=1 with back-to-back requests: one response per cycle, in order.
- Reset mid-transaction: assert rst_n while rsp_valid=1. Outputs go to reset values immediately, and a subsequent LW @0x10 returns 0.
